handler: RTL and testbench

HANDLER -- requirements
Module: handler

---
 rtl/handler_pkg.sv | 35 +++
 rtl/handler_trigger.sv | 130 +++++++++++++
 rtl/handler.sv | 141 ++++++++++++++
 tb/tb_handler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handler_pkg.sv
// handler_pkg: shared definitions for the glitch handler.
//   - arm mode encodings held in the low bits of the control word
//   - control word and status word bit positions
//   - sequencer state enum used by the trigger sub-module
//   - mode_armed(): decodes whether a mode word arms the handler
package handler_pkg;

    localparam logic [1:0] MODE_DISARM = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_MSB = 1;
    localparam int CTRL_SRC_BIT  = 4;

    localparam int STAT_ARMED  = 0;
    localparam int STAT_LOCKED = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_DONE   = 3;
    localparam int STAT_SRC    = 4;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_DELAY1,
        SEQ_PULSE,
        SEQ_DELAY2,
        SEQ_DONE
    } seq_state_t;

    // Mode 11 is reserved and behaves like disarm.
    function automatic logic mode_armed(input logic [1:0] mode);
        return (mode == MODE_CONT) || (mode == MODE_SINGLE);
    endfunction

endpackage

// File: rtl/handler_trigger.sv
// trigger: delay / pulse / delay sequencer driven by one 32-bit down-counter.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               returns the sequencer to idle and drops its outputs
//   start               fire request; honoured only while idle
//   delay_1st, delay_2nd, pulse_width   cycle counts, sampled on start
//   pulse               glitch output (registered)
//   done                one-cycle completion pulse (registered)
//   busy                high whenever the sequencer is not idle
//
//   state      | meaning
//   -----------+------------------------------------------------
//   SEQ_IDLE   | waiting for a fire request
//   SEQ_DELAY1 | counting out the first delay
//   SEQ_PULSE  | glitch active for pulse_width cycles
//   SEQ_DELAY2 | counting out the second delay
//   SEQ_DONE   | single cycle that produces the done pulse
module trigger
    import handler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] delay_1st,
    input  logic [31:0] delay_2nd,
    input  logic [31:0] pulse_width,
    output logic        pulse,
    output logic        done,
    output logic        busy
);

    seq_state_t  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] width_q, width_d;
    logic [31:0] d2_q, d2_d;

    // Zero-length stages are skipped in the same cycle; the counter is
    // loaded with the length of whichever stage is entered, and a stage
    // ends on the cycle its count reaches 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        d2_d    = d2_q;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    width_d = pulse_width;
                    d2_d    = delay_2nd;
                    if (delay_1st != 32'd0) begin
                        state_d = SEQ_DELAY1;
                        cnt_d   = delay_1st;
                    end else if (pulse_width != 32'd0) begin
                        state_d = SEQ_PULSE;
                        cnt_d   = pulse_width;
                    end else if (delay_2nd != 32'd0) begin
                        state_d = SEQ_DELAY2;
                        cnt_d   = delay_2nd;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_DELAY1: begin
                if (cnt_q == 32'd1) begin
                    if (width_q != 32'd0) begin
                        state_d = SEQ_PULSE;
                        cnt_d   = width_q;
                    end else if (d2_q != 32'd0) begin
                        state_d = SEQ_DELAY2;
                        cnt_d   = d2_q;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            SEQ_PULSE: begin
                if (cnt_q == 32'd1) begin
                    if (d2_q != 32'd0) begin
                        state_d = SEQ_DELAY2;
                        cnt_d   = d2_q;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            SEQ_DELAY2: begin
                if (cnt_q == 32'd1) begin
                    state_d = SEQ_DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
        if (clear) begin
            state_d = SEQ_IDLE;
            cnt_d   = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= 32'd0;
            width_q <= 32'd0;
            d2_q    <= 32'd0;
            pulse   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            d2_q    <= d2_d;
            // Outputs are registered from the current state, which puts the
            // glitch edge delay_1st+2 cycles after the completing strobe.
            pulse   <= !clear && (state_q == SEQ_PULSE);
            done    <= !clear && (state_q == SEQ_DONE);
        end
    end

    assign busy = (state_q != SEQ_IDLE);

endmodule

// File: rtl/handler.sv
// handler: arms on a control write, watches either a UART byte stream for a
// pattern match or counts external trigger edges, and launches the
// delay/pulse/delay glitch sequencer on a fire request.
// Ports:
//   i_CLK, i_RST        clock, asynchronous active-high reset
//   i_CONTROL(_WR)      mode word and its write strobe
//   i_TRIGGER           external trigger (already synchronous)
//   i_RX, i_RX_READY    received byte and its valid (rising edge counts)
//   i_DELAY_1ST, i_DELAY_2ND, i_PULSE_WIDTH   sequencer timing in cycles
//   i_BUFFER, i_BUF_LEN match pattern and index of its last byte
//   o_STATUS            {0,0,0,source,done seen,busy,locked,armed}
//   o_DEBUG             {0, match index}
//   o_LOCK, o_STOP_N, o_TRIGGER, o_DONE   lock flag, run enable, glitch, done
module handler
    import handler_pkg::*;
#(
    parameter int TRIGGER_MIN_CNT = 3
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    input  logic [7:0]    i_CONTROL,
    input  logic          i_CONTROL_WR,
    input  logic          i_TRIGGER,
    input  logic [7:0]    i_RX,
    input  logic          i_RX_READY,
    input  logic [31:0]   i_DELAY_1ST,
    input  logic [31:0]   i_DELAY_2ND,
    input  logic [31:0]   i_PULSE_WIDTH,
    input  logic [1023:0] i_BUFFER,
    input  logic [6:0]    i_BUF_LEN,
    output logic [7:0]    o_STATUS,
    output logic [7:0]    o_DEBUG,
    output logic          o_LOCK,
    output logic          o_STOP_N,
    output logic          o_TRIGGER,
    output logic          o_DONE
);

    logic [1:0]  mode_q;
    logic        src_q;
    logic [6:0]  idx_q;
    logic [31:0] edge_cnt_q;
    logic        rx_ready_q, trig_in_q;
    logic        fire_q, lock_q, done_seen_q;

    logic        armed, seq_busy, seq_done, seq_clear;
    logic        rx_edge, trig_edge, uart_step, ext_step;
    logic        uart_hit, ext_hit;
    logic [7:0]  pat_byte;
    logic        ctrl_unused;

    assign ctrl_unused = ^{i_CONTROL[7:5], i_CONTROL[3:2]};

    assign armed     = mode_armed(mode_q);
    assign rx_edge   = i_RX_READY & ~rx_ready_q;
    assign trig_edge = i_TRIGGER & ~trig_in_q;
    assign pat_byte  = i_BUFFER[{idx_q, 3'b000} +: 8];

    // A pending fire request counts as busy so no byte is consumed in the
    // cycle between a completed match and the sequencer leaving idle.
    assign uart_step = armed & ~lock_q & ~src_q & ~seq_busy & ~fire_q & rx_edge;
    assign ext_step  = armed & ~lock_q & src_q & trig_edge;
    assign uart_hit  = uart_step & (i_RX == pat_byte) & (idx_q == i_BUF_LEN);
    assign ext_hit   = ext_step & ((edge_cnt_q + 32'd1) == 32'(TRIGGER_MIN_CNT));

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            mode_q      <= MODE_DISARM;
            src_q       <= 1'b0;
            idx_q       <= 7'd0;
            edge_cnt_q  <= 32'd0;
            rx_ready_q  <= 1'b0;
            trig_in_q   <= 1'b0;
            fire_q      <= 1'b0;
            lock_q      <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            rx_ready_q <= i_RX_READY;
            trig_in_q  <= i_TRIGGER;
            if (i_CONTROL_WR) begin
                mode_q      <= i_CONTROL[CTRL_MODE_MSB:CTRL_MODE_LSB];
                src_q       <= i_CONTROL[CTRL_SRC_BIT];
                idx_q       <= 7'd0;
                edge_cnt_q  <= 32'd0;
                fire_q      <= 1'b0;
                lock_q      <= 1'b0;
                done_seen_q <= 1'b0;
            end else begin
                fire_q <= uart_hit | ext_hit;
                if ((uart_hit | ext_hit) && (mode_q == MODE_SINGLE)) begin
                    lock_q <= 1'b1;
                end
                if (uart_step) begin
                    if (i_RX == pat_byte) begin
                        idx_q <= (idx_q == i_BUF_LEN) ? 7'd0 : idx_q + 7'd1;
                    end else begin
                        // Restart the match, reusing this byte if it opens the pattern.
                        idx_q <= (i_RX == i_BUFFER[7:0]) ? 7'd1 : 7'd0;
                    end
                end
                if (ext_step) begin
                    edge_cnt_q <= ext_hit ? 32'd0 : edge_cnt_q + 32'd1;
                end
                if (seq_done) begin
                    done_seen_q <= 1'b1;
                end
            end
        end
    end

    // A control write or disarm takes priority over any running sequence.
    assign seq_clear = i_CONTROL_WR | ~armed;

    trigger u_trigger (
        .clk         (i_CLK),
        .rst         (i_RST),
        .clear       (seq_clear),
        .start       (fire_q),
        .delay_1st   (i_DELAY_1ST),
        .delay_2nd   (i_DELAY_2ND),
        .pulse_width (i_PULSE_WIDTH),
        .pulse       (o_TRIGGER),
        .done        (seq_done),
        .busy        (seq_busy)
    );

    always_comb begin
        o_STATUS              = 8'd0;
        o_STATUS[STAT_ARMED]  = armed;
        o_STATUS[STAT_LOCKED] = lock_q;
        o_STATUS[STAT_BUSY]   = seq_busy;
        o_STATUS[STAT_DONE]   = done_seen_q;
        o_STATUS[STAT_SRC]    = src_q;
    end

    assign o_DEBUG  = {1'b0, idx_q};
    assign o_LOCK   = lock_q;
    assign o_STOP_N = armed;
    assign o_DONE   = seq_done;

endmodule

// File: tb/tb_handler.sv
module tb_handler;

    logic          i_CLK = 1'b0;
    logic          i_RST = 1'b1;
    logic [7:0]    i_CONTROL = 8'd0;
    logic          i_CONTROL_WR = 1'b0;
    logic          i_TRIGGER = 1'b0;
    logic [7:0]    i_RX = 8'd0;
    logic          i_RX_READY = 1'b0;
    logic [31:0]   i_DELAY_1ST = 32'd0;
    logic [31:0]   i_DELAY_2ND = 32'd0;
    logic [31:0]   i_PULSE_WIDTH = 32'd0;
    logic [1023:0] i_BUFFER = '0;
    logic [6:0]    i_BUF_LEN = 7'd0;
    logic [7:0]    o_STATUS, o_DEBUG;
    logic          o_LOCK, o_STOP_N, o_TRIGGER, o_DONE;

    always #5 i_CLK = ~i_CLK;

    handler #(.TRIGGER_MIN_CNT(3)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_CONTROL(i_CONTROL), .i_CONTROL_WR(i_CONTROL_WR),
        .i_TRIGGER(i_TRIGGER), .i_RX(i_RX), .i_RX_READY(i_RX_READY),
        .i_DELAY_1ST(i_DELAY_1ST), .i_DELAY_2ND(i_DELAY_2ND), .i_PULSE_WIDTH(i_PULSE_WIDTH),
        .i_BUFFER(i_BUFFER), .i_BUF_LEN(i_BUF_LEN), .o_STATUS(o_STATUS), .o_DEBUG(o_DEBUG),
        .o_LOCK(o_LOCK), .o_STOP_N(o_STOP_N), .o_TRIGGER(o_TRIGGER), .o_DONE(o_DONE)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rise_q[$], fall_q[$], done_q[$];
    int exp_rise[$], exp_fall[$], exp_done[$];
    int st_cyc[$];
    logic [7:0] st_byte[$];
    logic [7:0] pat[$];
    int cfg_d1, cfg_w, cfg_d2;
    int exp_idx;
    logic prev_trig = 1'b0;

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] status;
        logic       stop_n;
    } ctrl_vec_t;
    ctrl_vec_t tbl[9];

    always @(posedge i_CLK) cyc <= cyc + 1;

    // Event log: cycle numbers at which the glitch rises/falls and done pulses.
    always @(negedge i_CLK) begin
        if (o_TRIGGER && !prev_trig) rise_q.push_back(cyc);
        if (!o_TRIGGER && prev_trig) fall_q.push_back(cyc);
        if (o_DONE) done_q.push_back(cyc);
        prev_trig = o_TRIGGER;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge i_CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_ctrl(input logic [7:0] v);
        i_CONTROL = v;
        i_CONTROL_WR = 1'b1;
        tick();
        i_CONTROL_WR = 1'b0;
    endtask

    task automatic clear_logs();
        rise_q.delete(); fall_q.delete(); done_q.delete();
        st_cyc.delete(); st_byte.delete();
    endtask

    task automatic set_pattern(input string s);
        pat.delete();
        i_BUFFER = '0;
        for (int i = 0; i < s.len(); i++) begin
            pat.push_back(s[i]);
            i_BUFFER[8*i +: 8] = s[i];
        end
        i_BUF_LEN = 7'(s.len() - 1);
    endtask

    task automatic setup(input logic [7:0] ctrl, input int d1, input int w, input int d2);
        cfg_d1 = d1; cfg_w = w; cfg_d2 = d2;
        i_DELAY_1ST = 32'(d1); i_PULSE_WIDTH = 32'(w); i_DELAY_2ND = 32'(d2);
        write_ctrl(ctrl);
        clear_logs();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_RX = b;
        i_RX_READY = 1'b1;
        tick();
        st_cyc.push_back(cyc);
        st_byte.push_back(b);
        i_RX_READY = 1'b0;
        tick(1 + gap);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    // A fire on strobe cycle s: glitch high over [s+D1+2, s+D1+W+1], done at s+D1+W+D2+2.
    task automatic expect_fire(input int s);
        if (cfg_w > 0) begin
            exp_rise.push_back(s + cfg_d1 + 2);
            exp_fall.push_back(s + cfg_d1 + cfg_w + 2);
        end
        exp_done.push_back(s + cfg_d1 + cfg_w + cfg_d2 + 2);
    endtask

    // Reference matcher over the logged byte stream; bytes arriving while a
    // sequence is in flight (until its done cycle) or after a single-shot lock are dropped.
    task automatic model_uart(input bit single);
        int idx, busy_until, e;
        bit locked;
        logic [7:0] b;
        idx = 0; busy_until = -1; locked = 0;
        exp_rise.delete(); exp_fall.delete(); exp_done.delete();
        for (int i = 0; i < st_cyc.size(); i++) begin
            e = st_cyc[i];
            b = st_byte[i];
            if (!locked && e > busy_until) begin
                if (b == pat[idx]) begin
                    if (idx == pat.size() - 1) begin
                        idx = 0;
                        expect_fire(e);
                        busy_until = e + cfg_d1 + cfg_w + cfg_d2 + 2;
                        if (single) locked = 1;
                    end else begin
                        idx++;
                    end
                end else begin
                    idx = (b == pat[0]) ? 1 : 0;
                end
            end
        end
        exp_idx = idx;
    endtask

    task automatic compare_events(input string name);
        check({name, " rise count"}, rise_q.size(), exp_rise.size());
        check({name, " done count"}, done_q.size(), exp_done.size());
        for (int i = 0; i < exp_rise.size(); i++) begin
            if (i < rise_q.size()) check({name, " rise cycle"}, rise_q[i], exp_rise[i]);
            if (i < fall_q.size()) check({name, " fall cycle"}, fall_q[i], exp_fall[i]);
        end
        for (int i = 0; i < exp_done.size(); i++)
            if (i < done_q.size()) check({name, " done cycle"}, done_q[i], exp_done[i]);
    endtask

    initial begin
        string alpha;
        string s;
        int t, mode, len, n;

        tbl[0] = '{8'h00, 8'h00, 1'b0};
        tbl[1] = '{8'h01, 8'h01, 1'b1};
        tbl[2] = '{8'h02, 8'h01, 1'b1};
        tbl[3] = '{8'h03, 8'h00, 1'b0};
        tbl[4] = '{8'h11, 8'h11, 1'b1};
        tbl[5] = '{8'h12, 8'h11, 1'b1};
        tbl[6] = '{8'h13, 8'h10, 1'b0};
        tbl[7] = '{8'hEE, 8'h01, 1'b1};
        tbl[8] = '{8'hFD, 8'h11, 1'b1};

        // Reset state
        tick(3);
        check("reset status", o_STATUS, 0);
        check("reset debug", o_DEBUG, 0);
        check("reset stop_n", o_STOP_N, 0);
        check("reset trigger", o_TRIGGER, 0);
        check("reset lock", o_LOCK, 0);
        check("reset done", o_DONE, 0);
        i_RST = 1'b0;
        tick(2);

        // Control word decode
        foreach (tbl[i]) begin
            write_ctrl(tbl[i].ctrl);
            check($sformatf("ctrl %02h status", tbl[i].ctrl), o_STATUS, tbl[i].status);
            check($sformatf("ctrl %02h stop_n", tbl[i].ctrl), o_STOP_N, tbl[i].stop_n);
        end

        set_pattern("0123");

        // Single shot, no first delay, 16-cycle glitch
        setup(8'h02, 0, 16, 0);
        send_str(" 01", 0);
        check("idx after 01", o_DEBUG, 2);
        send_str("234", 0);
        tick(30);
        model_uart(1);
        compare_events("single d1=0");
        if (rise_q.size() == 1 && fall_q.size() == 1) begin
            check("single rise offset", rise_q[0] - st_cyc[4], 2);
            check("single width", fall_q[0] - rise_q[0], 16);
        end
        check("single lock", o_LOCK, 1);
        check("single status", o_STATUS, 8'h0B);

        // First and second delays
        setup(8'h02, 7, 16, 20);
        send_str(" 01234", 0);
        tick(60);
        model_uart(1);
        compare_events("delays");
        if (rise_q.size() == 1 && fall_q.size() == 1 && done_q.size() == 1) begin
            check("delay rise offset", rise_q[0] - st_cyc[4], 9);
            check("delay done after fall", done_q[0] - fall_q[0], 20);
        end

        // Continuous mode, stream three times
        setup(8'h01, 0, 16, 0);
        for (int r = 0; r < 3; r++) begin
            send_str(" 01234", 0);
            tick(30);
        end
        model_uart(0);
        compare_events("continuous x3");
        check("continuous glitches", rise_q.size(), 3);
        check("continuous lock", o_LOCK, 0);

        // Single shot, stream three times, then rearm
        setup(8'h02, 0, 16, 0);
        for (int r = 0; r < 3; r++) begin
            send_str(" 01234", 0);
            tick(30);
        end
        model_uart(1);
        compare_events("single x3");
        check("single x3 glitches", rise_q.size(), 1);
        write_ctrl(8'h00);
        check("disarm lock", o_LOCK, 0);
        check("disarm stop_n", o_STOP_N, 0);
        send_str(" 01234", 0);
        tick(30);
        check("disarmed glitches", rise_q.size(), 1);
        setup(8'h02, 0, 16, 0);
        send_str(" 01234", 0);
        tick(30);
        check("rearmed glitches", rise_q.size(), 1);

        // External trigger, fires on 3rd edge
        setup(8'h12, 3, 4, 0);
        t = 0;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) check("ext no early glitch", rise_q.size(), 0);
            i_TRIGGER = 1'b1;
            tick();
            t = cyc;
            i_TRIGGER = 1'b0;
            tick(3);
        end
        tick(20);
        check("ext rise count", rise_q.size(), 1);
        if (rise_q.size() == 1 && fall_q.size() == 1) begin
            check("ext rise offset", rise_q[0] - t, 5);
            check("ext width", fall_q[0] - rise_q[0], 4);
        end
        check("ext lock", o_LOCK, 1);

        // Zero width: no glitch, done 6 cycles after the fire request
        setup(8'h01, 0, 0, 5);
        send_str(" 01234", 0);
        tick(20);
        check("w0 rise count", rise_q.size(), 0);
        check("w0 done count", done_q.size(), 1);
        if (done_q.size() == 1) check("w0 done offset", done_q[0] - (st_cyc[4] + 1), 6);

        // Timing values sampled at fire; later changes ignored
        setup(8'h01, 6, 5, 3);
        send_str("0123", 0);
        i_DELAY_1ST = 32'd20; i_PULSE_WIDTH = 32'd50; i_DELAY_2ND = 32'd40;
        tick(30);
        model_uart(0);
        compare_events("sampled cfg");

        // Control write mid-glitch drops the glitch next cycle
        setup(8'h01, 0, 30, 0);
        send_str("0123", 0);
        tick(5);
        check("pre-abort trigger", o_TRIGGER, 1);
        write_ctrl(8'h01);
        check("abort trigger", o_TRIGGER, 0);
        tick(40);
        check("abort no done", done_q.size(), 0);

        // Randomised streams against the reference matcher
        alpha = "abc";
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(1, 4);
            s = "";
            for (int k = 0; k < len; k++) s = {s, string'(alpha[$urandom_range(0, 1)])};
            set_pattern(s);
            mode = $urandom_range(1, 2);
            setup(8'(mode), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
            n = $urandom_range(12, 30);
            for (int k = 0; k < n; k++) send_byte(alpha[$urandom_range(0, 2)], $urandom_range(0, 2));
            tick(20);
            model_uart(mode == 2);
            compare_events($sformatf("rand %0d", it));
            check($sformatf("rand %0d idx", it), o_DEBUG, exp_idx);
        end

        // Asynchronous reset in the middle of a glitch
        set_pattern("0123");
        setup(8'h01, 0, 20, 0);
        send_str("0123", 0);
        tick(3);
        check("pre-reset trigger", o_TRIGGER, 1);
        #2 i_RST = 1'b1;
        #1;
        check("async reset trigger", o_TRIGGER, 0);
        check("async reset status", o_STATUS, 0);
        check("async reset stop_n", o_STOP_N, 0);
        tick(2);
        i_RST = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
